hsv_core_decode_fifo: RTL and testbench

Parametrised decode-to-issue buffer that replaces the fixed two-entry skid buffer between decode and issue. It holds up to DEPTH decoded packets and uses a valid/ready handshake on both sides. It implements the pipeline flush_req/flush_ack handshake. It adds a trap-lock mode: once a packet flagged as trap (illegal opcode or fetch fault) is enqueued, decode stops accepting packets until the next flush, because commit will redirect anyway.

---
 rtl/hsv_core_decode_fifo_pkg.sv | 8 +
 rtl/hsv_core_decode_fifo.sv | 96 +++++++++
 tb/tb_hsv_core_decode_fifo.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsv_core_decode_fifo_pkg.sv
// Shared helpers for the decode-to-issue buffer.
package hsv_core_decode_fifo_pkg;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/hsv_core_decode_fifo.sv
// Decode-to-issue ring buffer with valid/ready on both sides, flush handshake
// and an optional trap lock that stops enqueue once a trap packet is buffered.
module hsv_core_decode_fifo
  import hsv_core_decode_fifo_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 4,
  parameter int TRAP_LOCK = 1
) (
  input  logic                       clk_core,
  input  logic                       rst_core,
  input  logic                       flush_req,
  output logic                       flush_ack,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_trap,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_trap,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       trap_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic             LOCK_EN  = (TRAP_LOCK != 0);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_depth_check
      $error("hsv_core_decode_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH:0]     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               trap_pending_q;
  logic               flush_ack_q;
  logic               push;
  logic               pop;

  // Handshake outputs depend on registered state only.
  assign ready_o      = (count_q != CNT_FULL) & ~(LOCK_EN & trap_pending_q);
  assign valid_o      = (count_q != '0);
  assign push         = valid_i & ready_o;
  assign pop          = valid_o & ready_i;
  assign out_data     = mem[rd_ptr_q][WIDTH-1:0];
  assign out_trap     = mem[rd_ptr_q][WIDTH];
  assign count        = count_q;
  assign trap_pending = trap_pending_q;
  assign flush_ack    = flush_ack_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      trap_pending_q <= 1'b0;
      flush_ack_q    <= 1'b1;
    end else begin
      flush_ack_q <= flush_req;
      if (flush_req) begin
        wr_ptr_q       <= '0;
        rd_ptr_q       <= '0;
        count_q        <= '0;
        trap_pending_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
        if (push && in_trap) trap_pending_q <= 1'b1;
      end
    end
  end

  // Storage is not reset; stale entries are hidden by count.
  always_ff @(posedge clk_core) begin
    if (push && !flush_req) mem[wr_ptr_q] <= {in_trap, in_data};
  end

endmodule

// File: tb/tb_hsv_core_decode_fifo.sv
// Directed bench: a TRAP_LOCK=1 and a TRAP_LOCK=0 instance share stimulus.
module tb_hsv_core_decode_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush_req = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_trap = 1'b0;

  logic       flush_ack0, ready_o0, valid_o0, out_trap0, trap_pending0;
  logic [7:0] out_data0;
  logic [2:0] count0;
  logic       flush_ack1, ready_o1, valid_o1, out_trap1, trap_pending1;
  logic [7:0] out_data1;
  logic [2:0] count1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hsv_core_decode_fifo #(.WIDTH(8), .DEPTH(4), .TRAP_LOCK(1)) dut0 (
    .clk_core(clk), .rst_core(rst), .flush_req(flush_req), .flush_ack(flush_ack0),
    .valid_i(valid_i), .ready_o(ready_o0), .in_data(in_data), .in_trap(in_trap),
    .valid_o(valid_o0), .ready_i(ready_i), .out_data(out_data0), .out_trap(out_trap0),
    .count(count0), .trap_pending(trap_pending0));

  hsv_core_decode_fifo #(.WIDTH(8), .DEPTH(4), .TRAP_LOCK(0)) dut1 (
    .clk_core(clk), .rst_core(rst), .flush_req(flush_req), .flush_ack(flush_ack1),
    .valid_i(valid_i), .ready_o(ready_o1), .in_data(in_data), .in_trap(in_trap),
    .valid_o(valid_o1), .ready_i(ready_i), .out_data(out_data1), .out_trap(out_trap1),
    .count(count1), .trap_pending(trap_pending1));

  // Advance one cycle; occupancy must never exceed DEPTH (also catches underflow wrap).
  task automatic tick();
    @(posedge clk);
    #1;
    tests++;
    if (count0 > 3'd4 || count1 > 3'd4) begin
      fails++;
      $display("FAIL count_bound got %0d/%0d want <=4", count0, count1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush_req = 1'b0; valid_i = 1'b0; ready_i = 1'b0; in_trap = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({count0, valid_o0, trap_pending0, flush_ack0, ready_o0} !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL reset_state got cnt=%0d v=%b tp=%b ack=%b rdy=%b want 0 0 0 1 1",
               count0, valid_o0, trap_pending0, flush_ack0, ready_o0);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    valid_i = 1'b1; ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = vals[i];
      tick();
    end
    valid_i = 1'b0;
    tests++;
    if (count0 !== 3'd4 || ready_o0 !== 1'b0 || valid_o0 !== 1'b1) begin
      fails++;
      $display("FAIL full_state got cnt=%0d rdy=%b v=%b want 4 0 1", count0, ready_o0, valid_o0);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (valid_o0 !== 1'b1 || out_data0 !== vals[i]) begin
        fails++;
        $display("FAIL drain_order[%0d] got v=%b %h want 1 %h", i, valid_o0, out_data0, vals[i]);
      end
      tick();
    end
    ready_i = 1'b0;
    tests++;
    if (count0 !== 3'd0 || valid_o0 !== 1'b0) begin
      fails++;
      $display("FAIL drained got cnt=%0d v=%b want 0 0", count0, valid_o0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    do_reset();
    tests++;
    if (valid_o0 !== 1'b0) begin
      fails++;
      $display("FAIL empty_valid got %b want 0", valid_o0);
    end
    valid_i = 1'b1; in_data = 8'hA5;
    tick();
    tests++;
    if (valid_o0 !== 1'b1 || out_data0 !== 8'hA5) begin
      fails++;
      $display("FAIL first_latency got v=%b %h want 1 a5", valid_o0, out_data0);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp = (i == 0) ? 8'hA5 : 8'(i - 1);
      in_data = 8'(i);
      tests++;
      if (count0 !== 3'd1 || out_data0 !== exp) begin
        fails++;
        $display("FAIL stream[%0d] got cnt=%0d %h want 1 %h", i, count0, out_data0, exp);
      end
      tick();
    end
    valid_i = 1'b0;
    tests++;
    if (out_data0 !== 8'd19) begin
      fails++;
      $display("FAIL stream_tail got %h want 13", out_data0);
    end
    tick();
    ready_i = 1'b0;
    tests++;
    if (valid_o0 !== 1'b0) begin
      fails++;
      $display("FAIL stream_empty got v=%b want 0", valid_o0);
    end
  endtask

  task automatic test_trap_lock();
    do_reset();
    valid_i = 1'b1; ready_i = 1'b0;
    in_data = 8'h01; in_trap = 1'b0; tick();
    in_data = 8'h02; in_trap = 1'b1; tick();
    in_data = 8'h03; in_trap = 1'b0;
    tests++;
    if (trap_pending0 !== 1'b1 || ready_o0 !== 1'b0) begin
      fails++;
      $display("FAIL lock_on got tp=%b rdy=%b want 1 0", trap_pending0, ready_o0);
    end
    tests++;
    if (trap_pending1 !== 1'b1 || ready_o1 !== 1'b1) begin
      fails++;
      $display("FAIL nolock got tp=%b rdy=%b want 1 1", trap_pending1, ready_o1);
    end
    tick();
    valid_i = 1'b0;
    tests++;
    if (count0 !== 3'd2 || count1 !== 3'd3) begin
      fails++;
      $display("FAIL trap_counts got %0d/%0d want 2/3", count0, count1);
    end
    ready_i = 1'b1;
    tests++;
    if ({out_data0, out_trap0, out_data1, out_trap1} !== {8'h01, 1'b0, 8'h01, 1'b0}) begin
      fails++;
      $display("FAIL trap_head0 got %h/%b %h/%b want 01/0 01/0", out_data0, out_trap0, out_data1, out_trap1);
    end
    tick();
    tests++;
    if ({out_data0, out_trap0, out_data1, out_trap1} !== {8'h02, 1'b1, 8'h02, 1'b1}) begin
      fails++;
      $display("FAIL trap_head1 got %h/%b %h/%b want 02/1 02/1", out_data0, out_trap0, out_data1, out_trap1);
    end
    tick();
    tests++;
    if (valid_o0 !== 1'b0 || ready_o0 !== 1'b0 || valid_o1 !== 1'b1 || out_data1 !== 8'h03 || out_trap1 !== 1'b0) begin
      fails++;
      $display("FAIL trap_tail got v0=%b r0=%b v1=%b %h/%b want 0 0 1 03/0",
               valid_o0, ready_o0, valid_o1, out_data1, out_trap1);
    end
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    valid_i = 1'b1; ready_i = 1'b0;
    in_data = 8'h10; in_trap = 1'b0; tick();
    in_data = 8'h20; tick();
    in_data = 8'h30; in_trap = 1'b1; tick();
    in_trap = 1'b0;
    tests++;
    if (count0 !== 3'd3 || trap_pending0 !== 1'b1) begin
      fails++;
      $display("FAIL preflush got cnt=%0d tp=%b want 3 1", count0, trap_pending0);
    end
    in_data = 8'h40; ready_i = 1'b1; flush_req = 1'b1;
    tick();
    flush_req = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    tests++;
    if ({count0, valid_o0, trap_pending0, flush_ack0} !== {3'd0, 1'b0, 1'b0, 1'b1} ||
        {count1, flush_ack1} !== {3'd0, 1'b1}) begin
      fails++;
      $display("FAIL flush_clear got cnt=%0d v=%b tp=%b ack=%b cnt1=%0d want 0 0 0 1 0",
               count0, valid_o0, trap_pending0, flush_ack0, count1);
    end
    tick();
    tests++;
    if (flush_ack0 !== 1'b0 || ready_o0 !== 1'b1) begin
      fails++;
      $display("FAIL flush_ack_drop got ack=%b rdy=%b want 0 1", flush_ack0, ready_o0);
    end
    valid_i = 1'b1; in_data = 8'h55;
    tick();
    valid_i = 1'b0;
    tests++;
    if (count0 !== 3'd1 || valid_o0 !== 1'b1 || out_data0 !== 8'h55) begin
      fails++;
      $display("FAIL post_flush_push got cnt=%0d v=%b %h want 1 1 55", count0, valid_o0, out_data0);
    end
    // Two-cycle flush with a push held high: nothing enters, ack lasts through last+1.
    flush_req = 1'b1; valid_i = 1'b1; in_data = 8'h66;
    tick();
    tests++;
    if (count0 !== 3'd0 || flush_ack0 !== 1'b1) begin
      fails++;
      $display("FAIL multi_flush0 got cnt=%0d ack=%b want 0 1", count0, flush_ack0);
    end
    tick();
    flush_req = 1'b0; valid_i = 1'b0;
    tests++;
    if (count0 !== 3'd0 || flush_ack0 !== 1'b1 || valid_o0 !== 1'b0) begin
      fails++;
      $display("FAIL multi_flush1 got cnt=%0d ack=%b v=%b want 0 1 0", count0, flush_ack0, valid_o0);
    end
    tick();
    tests++;
    if (flush_ack0 !== 1'b0 || count0 !== 3'd0) begin
      fails++;
      $display("FAIL multi_flush_end got ack=%b cnt=%0d want 0 0", flush_ack0, count0);
    end
  endtask

  task automatic test_reset_mid();
    valid_i = 1'b1; ready_i = 1'b0;
    in_data = 8'h77; tick();
    in_data = 8'h88; tick();
    valid_i = 1'b0;
    tests++;
    if (count0 !== 3'd2 || flush_ack0 !== 1'b0) begin
      fails++;
      $display("FAIL prereset got cnt=%0d ack=%b want 2 0", count0, flush_ack0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({count0, valid_o0, flush_ack0, ready_o0} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid got cnt=%0d v=%b ack=%b rdy=%b want 0 0 1 1",
               count0, valid_o0, flush_ack0, ready_o0);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_trap_lock();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
